pop_timers: RTL and testbench
=============================

# pop_timers

Pulsed-optical-pumping (POP) sequence generator for a Ramsey-type atomic clock experiment. Running from the 2.5 MHz system clock, it produces a repeating frame of pulses: optical pump, microwave (MW) pulse, free-precession gap, second MW pulse, then optical probe with an ADC sample strobe. All durations are integer clock cycles (400 ns each). The four outputs drive the laser/AOM switches, the MW switch and the acquisition trigger.

## Interface
- `WIDTH`, 16: width of the duration counter; every duration parameter must fit in WIDTH bits.
- `PUMP_CYCLES`, 1000: pump pulse length (400 µs).
- `DEAD_CYCLES`, 5: guard gap after pump and after the second MW pulse.
- `MW_CYCLES`, 25: length of each MW pulse (10 µs).
- `RAMSEY_CYCLES`, 2500: free-precession gap between the MW pulses (1 ms).
- `PROBE_CYCLES`, 500: probe pulse length.
- `SAMPLE_DELAY`, 25: cycles from probe start to sample start.
- `SAMPLE_CYCLES`, 5: sample strobe length.
- `REST_CYCLES`, 10: all-low gap before the next frame.
- `clock_2_5M` in 1: 2.5 MHz clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pump` out 1: pump laser gate.
- `probe` out 1: probe laser gate.
- `MW` out 1: microwave gate.
- `sample` out 1: acquisition strobe.

## Operation
- FSM states, in order: PUMP, DEAD1, MW1, RAMSEY, MW2, DEAD2, PROBE, REST, then back to PUMP. Runs continuously and needs no trigger.
- Each state lasts exactly its parameter's number of cycles. A down-counter (WIDTH bits) is loaded with duration−1 on entry. The FSM advances when the count reaches 0.
- Output decode:
  - `pump`=1 only in PUMP.
  - `MW`=1 only in MW1 and MW2.
  - `probe`=1 only in PROBE.
  - `sample`=1 in PROBE for probe-relative cycles SAMPLE_DELAY .. SAMPLE_DELAY+SAMPLE_CYCLES−1, counting from 0.
- At most one of `pump`, `MW`, `probe` is high in any cycle. `sample` is only ever high while `probe` is high.
- Frame length = PUMP+2·DEAD+2·MW+RAMSEY+PROBE+REST = 4070 cycles with defaults.
- Parameter legality, enforced by elaboration-time checks:
  - every duration ≥ 1;
  - SAMPLE_DELAY+SAMPLE_CYCLES ≤ PROBE_CYCLES;
  - each duration < 2^WIDTH.

## Timing
- Reset (sampled high at an edge): all four outputs 0 after that edge, FSM forced to PUMP with the counter loaded, held as long as reset is high.
- Reset asserted mid-frame, in any state, aborts the frame the same way. No partial pulse continues.
- Outputs are registered, with no combinational path from state to pins.
- Let edge 1 be the first rising edge with reset low. `pump` rises at edge 1 (latency 1 cycle from the release of reset).
- Default schedule, in edges where the output is high after the edge:
  - `pump`: 1–1000;
  - `MW`: 1006–1030 and 3531–3555;
  - `probe`: 3561–4060;
  - `sample`: 3586–3590;
  - all low: 4061–4070;
  - `pump` again: 4071.
- No glitches: each output changes at most once per state boundary.

## Structure
- A shared package `pop_timers_pkg` holds the state enum and the default duration constants.
- One sub-module is natural: `pop_duration_counter` (loadable down-counter with zero flag, WIDTH parameter). The FSM and output registers stay in the top module.

## Test plan
- Reset hold: reset=1 for 10 cycles → all outputs 0 throughout. After release, `pump`=1 at edge 1 and stays high exactly 1000 cycles.
- Full frame with defaults: check each edge listed in Timing. `MW` pulses are 25 cycles wide and separated by exactly 2500 low cycles.
- Periodicity: run 50000 cycles → rising edges of `pump` at edges 1, 4071, 8141, … (period 4070). Each frame has 2 `MW` pulses, 1 `probe` pulse and 1 `sample` pulse of 5 cycles.
- Exclusivity assertion every cycle: pump+MW+probe ≤ 1, and sample implies probe.
- Mid-frame reset: assert reset during RAMSEY (edge 2000) for 3 cycles → outputs 0 from the next edge. After release, `pump` restarts at edge 1 with a full 1000-cycle pulse.
- Minimum parameters: all durations =1, SAMPLE_DELAY=0, SAMPLE_CYCLES=1 → frame of 8 cycles. The order is pump, low, MW, low, MW, low, probe together with sample, low.

Source files
------------

// File: rtl/pop_timers_pkg.sv
// Shared types and default durations for the pulsed-optical-pumping sequence generator.
// Phases are listed in frame order so the successor function is a plain walk.
package pop_timers_pkg;

   typedef enum logic [2:0] {
      ST_PUMP,
      ST_DEAD1,
      ST_MW1,
      ST_RAMSEY,
      ST_MW2,
      ST_DEAD2,
      ST_PROBE,
      ST_REST
   } state_t;

   localparam int DEF_WIDTH         = 16;
   localparam int DEF_PUMP_CYCLES   = 1000;
   localparam int DEF_DEAD_CYCLES   = 5;
   localparam int DEF_MW_CYCLES     = 25;
   localparam int DEF_RAMSEY_CYCLES = 2500;
   localparam int DEF_PROBE_CYCLES  = 500;
   localparam int DEF_SAMPLE_DELAY  = 25;
   localparam int DEF_SAMPLE_CYCLES = 5;
   localparam int DEF_REST_CYCLES   = 10;

   function automatic state_t next_phase(input state_t s);
      state_t n;
      case (s)
         ST_PUMP:   n = ST_DEAD1;
         ST_DEAD1:  n = ST_MW1;
         ST_MW1:    n = ST_RAMSEY;
         ST_RAMSEY: n = ST_MW2;
         ST_MW2:    n = ST_DEAD2;
         ST_DEAD2:  n = ST_PROBE;
         ST_PROBE:  n = ST_REST;
         default:   n = ST_PUMP;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pop_duration_counter.sv
// Loadable down-counter that parks at zero; the zero flag marks the last cycle of a phase.
module pop_duration_counter #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (srst)
         count_reg <= RESET_VALUE;
      else if (load)
         count_reg <= load_value;
      else if (count_reg != '0)
         count_reg <= count_reg - WIDTH'(1);
   end

   assign count = count_reg;
   assign zero  = (count_reg == '0);

endmodule

// File: rtl/pop_timers.sv
// POP frame sequencer: pump, dead, MW, Ramsey gap, MW, dead, probe (+ sample), rest, repeat.
// Outputs are a registered decode of the current phase, so pins lag the phase register by one edge.
module pop_timers
   import pop_timers_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int PUMP_CYCLES   = DEF_PUMP_CYCLES,
   parameter int DEAD_CYCLES   = DEF_DEAD_CYCLES,
   parameter int MW_CYCLES     = DEF_MW_CYCLES,
   parameter int RAMSEY_CYCLES = DEF_RAMSEY_CYCLES,
   parameter int PROBE_CYCLES  = DEF_PROBE_CYCLES,
   parameter int SAMPLE_DELAY  = DEF_SAMPLE_DELAY,
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
   parameter int REST_CYCLES   = DEF_REST_CYCLES
) (
   input  logic clock_2_5M,
   input  logic reset,
   output logic pump,
   output logic probe,
   output logic MW,
   output logic sample
);

   localparam int DURS [8] = '{PUMP_CYCLES, DEAD_CYCLES, MW_CYCLES, RAMSEY_CYCLES,
                               MW_CYCLES, DEAD_CYCLES, PROBE_CYCLES, REST_CYCLES};

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_dur_check
         if (DURS[gi] < 1 || (longint'(DURS[gi]) >> WIDTH) != 0) begin : g_bad
            $error("pop_timers: phase %0d duration %0d out of range", gi, DURS[gi]);
         end
      end
      if (SAMPLE_DELAY < 0 || SAMPLE_CYCLES < 1 ||
          SAMPLE_DELAY + SAMPLE_CYCLES > PROBE_CYCLES) begin : g_bad_sample
         $error("pop_timers: sample window does not fit inside the probe pulse");
      end
   endgenerate

   // Probe-relative cycle r corresponds to count = PROBE_CYCLES-1-r, so the window maps to a count range.
   localparam logic [WIDTH-1:0] SAMPLE_HI = WIDTH'(PROBE_CYCLES - 1 - SAMPLE_DELAY);
   localparam logic [WIDTH-1:0] SAMPLE_LO = WIDTH'(PROBE_CYCLES - SAMPLE_DELAY - SAMPLE_CYCLES);

   function automatic logic [WIDTH-1:0] load_for(input state_t s);
      logic [WIDTH-1:0] v;
      case (s)
         ST_PUMP:   v = WIDTH'(PUMP_CYCLES - 1);
         ST_DEAD1:  v = WIDTH'(DEAD_CYCLES - 1);
         ST_MW1:    v = WIDTH'(MW_CYCLES - 1);
         ST_RAMSEY: v = WIDTH'(RAMSEY_CYCLES - 1);
         ST_MW2:    v = WIDTH'(MW_CYCLES - 1);
         ST_DEAD2:  v = WIDTH'(DEAD_CYCLES - 1);
         ST_PROBE:  v = WIDTH'(PROBE_CYCLES - 1);
         default:   v = WIDTH'(REST_CYCLES - 1);
      endcase
      return v;
   endfunction

   state_t           state_reg, state_next;
   logic             load_next;
   logic [WIDTH-1:0] load_value_next;
   logic [WIDTH-1:0] count;
   logic             zero;
   logic             pump_reg, mw_reg, probe_reg, sample_reg;

   pop_duration_counter #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (WIDTH'(PUMP_CYCLES - 1))
   ) u_counter (
      .clk        (clock_2_5M),
      .srst       (reset),
      .load       (load_next),
      .load_value (load_value_next),
      .count      (count),
      .zero       (zero)
   );

   always_ff @(posedge clock_2_5M) begin
      if (reset)
         state_reg <= ST_PUMP;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next      = state_reg;
      load_next       = 1'b0;
      if (zero) begin
         state_next = next_phase(state_reg);
         load_next  = 1'b1;
      end
      load_value_next = load_for(state_next);
   end

   always_ff @(posedge clock_2_5M) begin
      if (reset) begin
         pump_reg   <= 1'b0;
         mw_reg     <= 1'b0;
         probe_reg  <= 1'b0;
         sample_reg <= 1'b0;
      end else begin
         pump_reg   <= (state_reg == ST_PUMP);
         mw_reg     <= (state_reg == ST_MW1) || (state_reg == ST_MW2);
         probe_reg  <= (state_reg == ST_PROBE);
         sample_reg <= (state_reg == ST_PROBE) && (count <= SAMPLE_HI) && (count >= SAMPLE_LO);
      end
   end

   assign pump   = pump_reg;
   assign MW     = mw_reg;
   assign probe  = probe_reg;
   assign sample = sample_reg;

endmodule

// File: tb/tb_pop_timers.sv
// Scoreboard bench: a default-parameter and a minimum-parameter instance, randomized resets,
// expectations derived from the frame schedule by plain arithmetic on edges since reset release.
module tb_pop_timers;

   localparam int NCYC = 50000;

   logic clk;
   logic rst_def, rst_min;
   logic pump_d, probe_d, mw_d, sample_d;
   logic pump_m, probe_m, mw_m, sample_m;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q [$];

   pop_timers u_def (
      .clock_2_5M (clk),
      .reset      (rst_def),
      .pump       (pump_d),
      .probe      (probe_d),
      .MW         (mw_d),
      .sample     (sample_d)
   );

   pop_timers #(
      .WIDTH         (16),
      .PUMP_CYCLES   (1),
      .DEAD_CYCLES   (1),
      .MW_CYCLES     (1),
      .RAMSEY_CYCLES (1),
      .PROBE_CYCLES  (1),
      .SAMPLE_DELAY  (0),
      .SAMPLE_CYCLES (1),
      .REST_CYCLES   (1)
   ) u_min (
      .clock_2_5M (clk),
      .reset      (rst_min),
      .pump       (pump_m),
      .probe      (probe_m),
      .MW         (mw_m),
      .sample     (sample_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {pump, MW, probe, sample} after edge t (t = 1 is the first edge with reset low).
   function automatic logic [3:0] schedule(input int t, input int pu, input int de, input int mw,
                                           input int ra, input int pr, input int sd, input int sc,
                                           input int re);
      int frame, p, mw2, ps;
      logic [3:0] o;
      frame = pu + 2*de + 2*mw + ra + pr + re;
      p     = (t - 1) % frame;
      mw2   = pu + de + mw + ra;
      ps    = pu + 2*de + 2*mw + ra;
      o[3]  = (p < pu);
      o[2]  = (p >= pu + de && p < pu + de + mw) || (p >= mw2 && p < mw2 + mw);
      o[1]  = (p >= ps && p < ps + pr);
      o[0]  = (p >= ps + sd && p < ps + sd + sc);
      return o;
   endfunction

   // Driver: picks the reset level for the coming edge and queues the response it implies.
   initial begin
      int t_def, t_min, hold_def, hold_min;
      logic [3:0] e_def, e_min;
      t_def = 0; t_min = 0; hold_def = 0; hold_min = 0;
      rst_def = 1'b1;
      rst_min = 1'b1;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc < 10)
            rst_def = 1'b1;
         else if (cyc >= 2009 && cyc <= 2011)
            rst_def = 1'b1;
         else if (hold_def > 0) begin
            rst_def  = 1'b1;
            hold_def = hold_def - 1;
         end else if (cyc > 27000 && $urandom_range(0, 2999) == 0) begin
            rst_def  = 1'b1;
            hold_def = $urandom_range(0, 3);
            $display("cycle %0d: random reset on default instance at frame edge %0d", cyc, t_def);
         end else
            rst_def = 1'b0;

         if (cyc < 3)
            rst_min = 1'b1;
         else if (hold_min > 0) begin
            rst_min  = 1'b1;
            hold_min = hold_min - 1;
         end else if ($urandom_range(0, 24) == 0) begin
            rst_min  = 1'b1;
            hold_min = $urandom_range(0, 2);
         end else
            rst_min = 1'b0;

         if (cyc == 2009)
            $display("cycle %0d: mid-frame reset in Ramsey gap at edge %0d", cyc, t_def + 1);

         if (rst_def) begin
            t_def = 0;
            e_def = 4'b0000;
         end else begin
            t_def = t_def + 1;
            e_def = schedule(t_def, 1000, 5, 25, 2500, 500, 25, 5, 10);
         end
         if (rst_min) begin
            t_min = 0;
            e_min = 4'b0000;
         end else begin
            t_min = t_min + 1;
            e_min = schedule(t_min, 1, 1, 1, 1, 1, 0, 1, 1);
         end
         exp_q.push_back({e_def, e_min});
         @(negedge clk);
      end
   end

   // Monitor: every edge both instances present a new output word.
   initial begin
      logic [7:0] e;
      logic [3:0] a_def, a_min, prev_def;
      int frames;
      prev_def = 4'b0000;
      frames   = 0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         a_def = {pump_d, mw_d, probe_d, sample_d};
         a_min = {pump_m, mw_m, probe_m, sample_m};
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_empty cycle %0d: actual queue depth 0, required >= 1", cyc);
         end else begin
            e = exp_q.pop_front();
            checks = checks + 2;
            if (a_def !== e[7:4]) begin
               errors = errors + 1;
               $display("FAIL default_outputs cycle %0d: actual pump/MW/probe/sample=%b required %b",
                        cyc, a_def, e[7:4]);
            end
            if (a_min !== e[3:0]) begin
               errors = errors + 1;
               $display("FAIL minimum_outputs cycle %0d: actual pump/MW/probe/sample=%b required %b",
                        cyc, a_min, e[3:0]);
            end
            if (e[7] && !prev_def[3]) begin
               frames = frames + 1;
               $display("cycle %0d: default frame %0d pump rise", cyc, frames);
            end
            prev_def = e[7:4];
         end
         checks = checks + 2;
         if ($countones(a_def[3:1]) > 1 || (a_def[0] && !a_def[1])) begin
            errors = errors + 1;
            $display("FAIL default_exclusive cycle %0d: actual %b, required one-hot-or-zero and sample within probe",
                     cyc, a_def);
         end
         if ($countones(a_min[3:1]) > 1 || (a_min[0] && !a_min[1])) begin
            errors = errors + 1;
            $display("FAIL minimum_exclusive cycle %0d: actual %b, required one-hot-or-zero and sample within probe",
                     cyc, a_min);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
